matrix_result_scanner: RTL
==========================

// Module: matrix_result_scanner
// PURPOSE
//   Downstream of the coprocessor. Captures the result matrix, determinant and operation code into a snapshot.
//   Steps through the N*N result elements, manually or automatically.
//   Drives a registered 24-bit value and the element index to the display_7seg digits.
// PARAMETERS
//   N          3         matrix dimension (N*N elements; N*N <= 16)
//   WIDTH      8         coprocessor input element width
//   ELEM_W     2*WIDTH+3 result element width (signed); 19 by default
//   STEP_TICKS 50000000  clock cycles per automatic step (1 s at 50 MHz); must be >= 2
// PORTS
//   CLOCK_50      in   1              system clock; all logic on rising edge
//   reset         in   1              synchronous, active-high
//   operacao      in   3              operation code presented to the coprocessor (6 = determinant)
//   resultado     in   N*N*ELEM_W     coprocessor result; element 0 = MSB slice, element N*N-1 = LSB slice
//   det           in   3*WIDTH+1      coprocessor determinant (signed)
//   capture       in   1              same-domain pulse: take snapshot
//   step          in   1              asynchronous, active-high, pre-debounced (top inverts KEY)
//   auto_mode     in   1              1 = advance every STEP_TICKS cycles
//   valor_display out  24             value to show on HEX5..HEX0
//   indice        out  4              current element index, 0..N*N-1
//   valid         out  1              snapshot held
// BEHAVIOUR
//   Reset values (reset=1 at a rising edge)
//     - Snapshot registers, index, tick counter and step sync/edge registers all go to 0.
//     - valor_display=0, indice=0, valid=0.
//     - Reset mid-scan abandons the scan; the first capture after reset is required before valid=1.
//   States
//     - EMPTY: valid=0 and display held at 0. Steps and ticks are ignored. capture -> SHOW.
//     - SHOW: valid=1. capture re-snapshots and stays in SHOW. Only reset returns to EMPTY.
//   Capture
//     - At the edge where capture=1: latch resultado, det[23:0] and operacao into snapshot.
//     - At the same edge: index <- 0 and tick counter <- 0.
//     - Live inputs are ignored at all other times.
//   Step path
//     - step passes through a 2-FF synchronizer, then a third register for rising-edge detection.
//     - One detected edge gives exactly one advance; holding step high gives no repeat.
//   Advance
//     - index <- index+1, and wraps from N*N-1 to 0.
//     - If the snapshot operacao = 6 (determinant), index stays 0 and advances are ignored.
//   Auto mode
//     - The counter runs only in SHOW with auto_mode=1.
//     - At STEP_TICKS-1: one advance, counter <- 0.
//     - auto_mode=0 clears the counter.
//     - Manual steps are also accepted in auto mode.
//     - A manual and an auto advance in the same cycle give a single +1.
//   Priority: reset > capture > advance. When capture and an advance coincide, index=0.
//   Output mapping
//     - If snapshot operacao = 6: valor_display = snapshot det[23:0].
//     - Otherwise: valor_display = sign-extension to 24 bits of element[index], i.e. bits [(N*N-index)*ELEM_W-1 -: ELEM_W].
//   Latency (valor_display and indice are registered)
//     - Display reflects a capture or index change 1 cycle later.
//     - step rising before edge 1 -> index changes at edge 3 -> display changes at edge 4.
// TESTING
//   T1 Reset
//      - Hold reset 2 cycles with step=1 and capture=1.
//      - Required: valor_display=0, indice=0, valid=0; no advance after release until a new edge occurs.
//   T2 Multiply, manual scan
//      - Inputs: A=1..9, B=9..1, operacao=2, capture.
//      - Display sequence: 0x00001E, 0x000018, 0x000012, 0x000054, 0x000045, 0x000036, 0x00008A, 0x000072, 0x00005A.
//      - A 9th step wraps to 0x00001E with indice=0.
//   T3 Subtract, sign extension
//      - Inputs: operacao=1, capture.
//      - Element 0 = -8 -> 0xFFFFF8. Element 4 = 0 -> 0x000000.
//   T4 Determinant
//      - Inputs: operacao=6, det=-3, capture.
//      - Required: 0xFFFFFD, indice stays 0 across 3 steps.
//      - Changing the det input afterwards has no effect until the next capture.
//   T5 Auto mode
//      - Setup: STEP_TICKS=4, auto_mode=1 after capture.
//      - Required: indice increments every 4 cycles and wraps after N*N steps.
//      - Dropping auto_mode freezes indice.
//   T6 Collision
//      - Sequence: hold indice=5, then assert capture in the cycle a step edge is detected.
//      - Required: indice=0 and the new snapshot is shown.

Source files
------------

// File: rtl/matrix_result_scanner.sv
// matrix_result_scanner
// Holds a snapshot of the coprocessor result matrix, determinant and
// operation code. The scanner steps through the N*N elements, either on
// debounced button edges or on a periodic tick. It presents the selected
// element, or the determinant, as a registered 24-bit display value.
module matrix_result_scanner #(
   parameter int N          = 3,
   parameter int WIDTH      = 8,
   parameter int ELEM_W     = 2*WIDTH+3,
   parameter int STEP_TICKS = 50000000
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic [2:0]               operacao,
   input  logic [N*N*ELEM_W-1:0]    resultado,
   input  logic [3*WIDTH:0]         det,
   input  logic                     capture,
   input  logic                     step,
   input  logic                     auto_mode,
   output logic [23:0]              valor_display,
   output logic [3:0]               indice,
   output logic                     valid
);

   localparam int NE    = N*N;
   localparam int RES_W = NE*ELEM_W;
   localparam int TW    = $clog2(STEP_TICKS);

   localparam logic [2:0]    OP_DET    = 3'd6;
   localparam logic [3:0]    IDX_LAST  = 4'(NE-1);
   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS-1);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

   // Sign-extends a result element to the 24-bit display width.
   function automatic logic [23:0] sext24(input logic signed [ELEM_W-1:0] e);
      logic signed [23:0] w;
      w = 24'(e);
      return w;
   endfunction

   state_t                state_q, state_d;
   logic [RES_W-1:0]      res_q, res_d;
   logic [23:0]           det_q, det_d;
   logic [2:0]            op_q, op_d;
   logic [3:0]            idx_q, idx_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic                  sync1_q, sync2_q, sync3_q;
   logic                  step_edge;
   logic                  auto_adv;
   logic                  advance;
   logic signed [ELEM_W-1:0] elem_sel;
   logic [23:0]           valor_q, valor_d;
   logic [3:0]            indice_q, indice_d;

   // The determinant is 3*WIDTH+1 bits wide, but only its low 24 bits are shown.
   logic [3*WIDTH-24:0]   unused_det;
   assign unused_det = det[3*WIDTH:24];

   // Step button: 2-FF synchronizer followed by an edge-detect register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= step;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign step_edge = sync2_q & ~sync3_q;

   // State, snapshot, index and tick registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_EMPTY;
         res_q   <= '0;
         det_q   <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         det_q   <= det_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
      end
   end

   // Next state: capture wins over any advance and restarts the scan at element 0.
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      det_d    = det_q;
      op_d     = op_q;
      idx_d    = idx_q;
      tick_d   = tick_q;
      auto_adv = 1'b0;
      advance  = 1'b0;

      case (state_q)
         S_EMPTY: begin
            // Nothing to scan yet: steps and ticks are ignored.
            idx_d  = '0;
            tick_d = '0;
            if (capture) begin
               state_d = S_SHOW;
               res_d   = resultado;
               det_d   = det[23:0];
               op_d    = operacao;
            end
         end

         S_SHOW: begin
            if (auto_mode) begin
               if (tick_q == TICK_LAST) begin
                  tick_d   = '0;
                  auto_adv = 1'b1;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               tick_d = '0;
            end

            // A manual edge and an auto tick together still give a single +1.
            // A determinant snapshot has one value only, so it never advances.
            advance = (step_edge | auto_adv) && (op_q != OP_DET);
            if (advance) begin
               idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
            end

            if (capture) begin
               res_d  = resultado;
               det_d  = det[23:0];
               op_d   = operacao;
               idx_d  = '0;
               tick_d = '0;
            end
         end

         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   // Select the element addressed by the index; element 0 is the top slice.
   always_comb begin
      elem_sel = '0;
      for (int k = 0; k < NE; k++) begin
         if (idx_q == 4'(k)) begin
            elem_sel = res_q[(NE-k)*ELEM_W-1 -: ELEM_W];
         end
      end
   end

   // Display value computed from the held snapshot only, never from live inputs.
   always_comb begin
      valor_d  = '0;
      indice_d = idx_q;
      if (state_q == S_SHOW) begin
         if (op_q == OP_DET) begin
            valor_d = det_q;
         end else begin
            valor_d = sext24(elem_sel);
         end
      end
   end

   // Registered display outputs, one cycle behind the snapshot and index.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         valor_q  <= '0;
         indice_q <= '0;
      end else begin
         valor_q  <= valor_d;
         indice_q <= indice_d;
      end
   end

   assign valor_display = valor_q;
   assign indice        = indice_q;
   assign valid         = (state_q == S_SHOW);

endmodule
